// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory-hierarchy types.
//   word_t         : 32-bit data/address word
//   memctl_state_t : memory arbiter FSM states
//   memsrc_t       : which cache owns the current memory access
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } memctl_state_t;

  typedef enum logic {
    SRC_I,
    SRC_D
  } memsrc_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-pair <-> memory arbiter <-> RAM signal bundle.
//   slave  : arbiter view (takes cache requests and ramload, drives waits/loads/RAM port)
//   master : environment view (caches and RAM)
// Cache side : iREN/iaddr/iwait/iload, dREN/dWEN/daddr/dstore/dwait/dload
// RAM side   : ramREN/ramWEN/ramaddr/ramstore/ramload
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  dwait;
  word_t dload;

  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter_ram_lat_timer.sv
// ram_lat_timer: paces one RAM access of RAM_LAT cycles.
//   clk, rst : clock and synchronous active-high reset
//   start    : pulse in the cycle before the access begins
//   busy     : high for the RAM_LAT access cycles
//   last     : high in the final access cycle (cnt == RAM_LAT-1)
module ram_lat_timer #(
  parameter int RAM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic last
);

  // Keep at least one counter bit so RAM_LAT=1 still elaborates cleanly.
  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LAT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign busy = busy_q;
  assign last = busy_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: responder side of the cache<->memory protocol. Arbitrates
// icache (read-only) and dcache (read/write) word requests onto a
// fixed-latency RAM port and returns load data with a one-cycle wait=0 pulse.
//   CLK, RST : clock and synchronous active-high reset
//   mem      : mem_arbiter_if.slave (cache request/response and RAM port)
// Parameter RAM_LAT (>=1): RAM cycles per access.
// Optional feature macro MEMCTL_RR_EN: round-robin between caches on
// simultaneous requests; undefined gives fixed dcache priority.
//
// state  | meaning
// IDLE   | waiting for a request; latches source, op, address, store data
// ACCESS | RAM strobed for RAM_LAT cycles; read data captured on the last
// DONE   | winner's wait low for one cycle with its load data
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int RAM_LAT = 2
) (
  input  logic          CLK,
  input  logic          RST,
  mem_arbiter_if.slave  mem
);

  memctl_state_t state_q;
  memsrc_t       src_q, src_d;
  logic          wr_q, wr_d;
  word_t         addr_q, store_q, data_q;
  logic          iwait_q, dwait_q;
  logic          i_req, d_req, start;
  logic          tmr_busy, tmr_last;

`ifdef MEMCTL_RR_EN
  memsrc_t       prio_q;
`endif

  assign i_req = mem.iREN;
  assign d_req = mem.dREN | mem.dWEN;
  assign start = (state_q == IDLE) && (i_req || d_req);

  always_comb begin
    src_d = d_req ? SRC_D : SRC_I;
`ifdef MEMCTL_RR_EN
    if (i_req && d_req) src_d = prio_q;
`endif
    // A write wins over a read when the dcache raises both strobes.
    wr_d = (src_d == SRC_D) && mem.dWEN;
  end

  ram_lat_timer #(.RAM_LAT(RAM_LAT)) u_timer (
    .clk   (CLK),
    .rst   (RST),
    .start (start),
    .busy  (tmr_busy),
    .last  (tmr_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      src_q   <= SRC_D;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      data_q  <= '0;
      iwait_q <= 1'b1;
      dwait_q <= 1'b1;
`ifdef MEMCTL_RR_EN
      prio_q  <= SRC_D;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ACCESS;
            src_q   <= src_d;
            wr_q    <= wr_d;
            addr_q  <= (src_d == SRC_D) ? mem.daddr : mem.iaddr;
            store_q <= (src_d == SRC_D) ? mem.dstore : '0;
          end
        end
        ACCESS: begin
          if (tmr_last) begin
            state_q <= DONE;
            if (!wr_q) data_q <= mem.ramload;
            if (src_q == SRC_D) dwait_q <= 1'b0;
            else                iwait_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          iwait_q <= 1'b1;
          dwait_q <= 1'b1;
`ifdef MEMCTL_RR_EN
          prio_q  <= (prio_q == SRC_D) ? SRC_I : SRC_D;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes follow the timer so they are high exactly for the access cycles.
  assign mem.ramREN   = tmr_busy & ~wr_q;
  assign mem.ramWEN   = tmr_busy &  wr_q;
  assign mem.ramaddr  = addr_q;
  assign mem.ramstore = store_q;

  assign mem.iwait = iwait_q;
  assign mem.dwait = dwait_q;
  // data_q is stale after a write, so loads are forced to zero then.
  assign mem.iload = (!iwait_q && !wr_q) ? data_q : '0;
  assign mem.dload = (!dwait_q && !wr_q) ? data_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int LAT = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic RST1 = 1'b1;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();
  mem_arbiter_if bus1 ();

  mem_arbiter #(.RAM_LAT(LAT)) dut (.CLK(CLK), .RST(RST), .mem(bus.slave));
  mem_arbiter #(.RAM_LAT(1))   dut1 (.CLK(CLK), .RST(RST1), .mem(bus1.slave));

  int checks = 0;
  int failures = 0;

  word_t ram_mem [16];
  word_t ref_mem [16];
  logic  use_fixed = 1'b1;
  word_t fixed_load = '0;

  assign bus.ramload  = use_fixed ? fixed_load : ram_mem[bus.ramaddr[5:2]];
  assign bus1.ramload = 32'hDEADBEEF;

  always @(posedge CLK) if (bus.ramWEN) ram_mem[bus.ramaddr[5:2]] <= bus.ramstore;

  typedef struct {
    logic  iren;
    word_t iaddr;
    logic  dren;
    logic  dwen;
    word_t daddr;
    word_t dstore;
    word_t load;
    logic  pulse;
    int    i_done;
    int    d_done;
    word_t exp_iload;
    word_t exp_dload;
    logic  acc_ren;
    logic  acc_wen;
    word_t acc_addr;
    word_t acc_store;
  } vec_t;

  vec_t vecs [6];

  function automatic vec_t mk(logic iren, word_t iaddr, logic dren, logic dwen, word_t daddr,
                              word_t dstore, word_t load, logic pulse, int i_done, int d_done,
                              word_t eil, word_t edl, logic aren, logic awen, word_t aaddr,
                              word_t astore);
    vec_t v;
    v.iren = iren; v.iaddr = iaddr; v.dren = dren; v.dwen = dwen; v.daddr = daddr;
    v.dstore = dstore; v.load = load; v.pulse = pulse; v.i_done = i_done; v.d_done = d_done;
    v.exp_iload = eil; v.exp_dload = edl; v.acc_ren = aren; v.acc_wen = awen;
    v.acc_addr = aaddr; v.acc_store = astore;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
  endtask

  task automatic do_reset(input int n);
    RST = 1'b1;
    repeat (n) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // random-phase model variables
  logic    i_act, d_act, have, in_acc, done_now, w_wr;
  memsrc_t w_src, prio_m;
  word_t   w_addr, w_store, w_data;
  int      g_c, done_c, free_c, op;
  logic [3:0] idx;

  initial begin
    bus1.iREN = 1'b0; bus1.iaddr = '0; bus1.dREN = 1'b0; bus1.dWEN = 1'b0;
    bus1.daddr = '0; bus1.dstore = '0;
    idle_inputs();

    // ---------------- reset with all requests high
    bus.iREN = 1'b1; bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h40;
    RST = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK);
      @(negedge CLK);
      chk($sformatf("rst%0d iwait", c), 32'(bus.iwait), 32'd1);
      chk($sformatf("rst%0d dwait", c), 32'(bus.dwait), 32'd1);
      chk($sformatf("rst%0d ramREN", c), 32'(bus.ramREN), 32'd0);
      chk($sformatf("rst%0d ramWEN", c), 32'(bus.ramWEN), 32'd0);
      chk($sformatf("rst%0d ramaddr", c), bus.ramaddr, 32'd0);
      chk($sformatf("rst%0d dload", c), bus.dload, 32'd0);
    end
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    chk("postrst iwait", 32'(bus.iwait), 32'd1);
    chk("postrst dwait", 32'(bus.dwait), 32'd1);
    chk("postrst ramREN", 32'(bus.ramREN), 32'd0);
    chk("postrst ramWEN", 32'(bus.ramWEN), 32'd0);
    @(posedge CLK); #1;
    idle_inputs();

    // ---------------- table-driven single-transaction vectors
    vecs[0] = mk(0, 0, 1, 0, 32'h100, 0, 32'hDEADBEEF, 0, -1, 3, 0, 32'hDEADBEEF,
                 1, 0, 32'h100, 0);
    vecs[1] = mk(0, 0, 0, 1, 32'h3100, 32'h5, 32'hFFFFFFFF, 0, -1, 3, 0, 0,
                 0, 1, 32'h3100, 32'h5);
    vecs[2] = mk(1, 32'h0, 1, 0, 32'h200, 0, 32'h11112222, 0, 7, 3, 32'h11112222,
                 32'h11112222, 1, 0, 32'h200, 0);
    vecs[3] = mk(0, 0, 1, 1, 32'h40, 32'hA5A5, 32'h77777777, 0, -1, 3, 0, 0,
                 0, 1, 32'h40, 32'hA5A5);
    vecs[4] = mk(1, 32'h80, 0, 0, 0, 0, 32'h12345678, 0, 3, -1, 32'h12345678, 0,
                 1, 0, 32'h80, 0);
    vecs[5] = mk(0, 0, 1, 0, 32'h104, 0, 32'hCAFEF00D, 1, -1, 3, 0, 32'hCAFEF00D,
                 1, 0, 32'h104, 0);

    for (int v = 0; v < 6; v++) begin
      idle_inputs();
      do_reset(1);
      use_fixed = 1'b1;
      fixed_load = vecs[v].load;
      bus.iREN = vecs[v].iren; bus.iaddr = vecs[v].iaddr;
      bus.dREN = vecs[v].dren; bus.dWEN = vecs[v].dwen;
      bus.daddr = vecs[v].daddr; bus.dstore = vecs[v].dstore;
      for (int c = 0; c < 10; c++) begin
        @(negedge CLK);
        chk($sformatf("v%0d c%0d iwait", v, c), 32'(bus.iwait), (c == vecs[v].i_done) ? 32'd0 : 32'd1);
        chk($sformatf("v%0d c%0d dwait", v, c), 32'(bus.dwait), (c == vecs[v].d_done) ? 32'd0 : 32'd1);
        chk($sformatf("v%0d c%0d iload", v, c), bus.iload, (c == vecs[v].i_done) ? vecs[v].exp_iload : 32'd0);
        chk($sformatf("v%0d c%0d dload", v, c), bus.dload, (c == vecs[v].d_done) ? vecs[v].exp_dload : 32'd0);
        if (c == 1 || c == 2) begin
          chk($sformatf("v%0d c%0d ramREN", v, c), 32'(bus.ramREN), 32'(vecs[v].acc_ren));
          chk($sformatf("v%0d c%0d ramWEN", v, c), 32'(bus.ramWEN), 32'(vecs[v].acc_wen));
          chk($sformatf("v%0d c%0d ramaddr", v, c), bus.ramaddr, vecs[v].acc_addr);
          if (vecs[v].acc_wen)
            chk($sformatf("v%0d c%0d ramstore", v, c), bus.ramstore, vecs[v].acc_store);
        end else if (c == 0 || c == 3) begin
          chk($sformatf("v%0d c%0d ramREN", v, c), 32'(bus.ramREN), 32'd0);
          chk($sformatf("v%0d c%0d ramWEN", v, c), 32'(bus.ramWEN), 32'd0);
        end
        @(posedge CLK); #1;
        if (c == vecs[v].i_done) bus.iREN = 1'b0;
        if (c == vecs[v].d_done || (vecs[v].pulse && c == 0)) begin
          bus.dREN = 1'b0; bus.dWEN = 1'b0;
        end
      end
    end

    // ---------------- both caches holding requests continuously
    idle_inputs();
    do_reset(1);
    fixed_load = 32'h0BADF00D;
    bus.iREN = 1'b1; bus.iaddr = 32'h0; bus.dREN = 1'b1; bus.daddr = 32'h200;
    for (int c = 0; c < 13; c++) begin
      logic ei, ed;
      @(negedge CLK);
`ifdef MEMCTL_RR_EN
      ei = (c == 7);
      ed = (c == 3 || c == 11);
`else
      ei = 1'b0;
      ed = (c == 3 || c == 7 || c == 11);
`endif
      chk($sformatf("hold c%0d iwait", c), 32'(bus.iwait), ei ? 32'd0 : 32'd1);
      chk($sformatf("hold c%0d dwait", c), 32'(bus.dwait), ed ? 32'd0 : 32'd1);
      @(posedge CLK); #1;
    end
    idle_inputs();

    // ---------------- reset in the first ACCESS cycle, request held
    do_reset(1);
    fixed_load = 32'hDEADBEEF;
    bus.dREN = 1'b1; bus.daddr = 32'h100;
    @(negedge CLK);
    chk("midrst c0 dwait", 32'(bus.dwait), 32'd1);
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);
    chk("midrst c1 ramREN", 32'(bus.ramREN), 32'd1);
    @(posedge CLK); #1 RST = 1'b0;
    for (int c = 2; c < 7; c++) begin
      @(negedge CLK);
      chk($sformatf("midrst c%0d dwait", c), 32'(bus.dwait), (c == 5) ? 32'd0 : 32'd1);
      chk($sformatf("midrst c%0d ramREN", c), 32'(bus.ramREN), (c == 3 || c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("midrst c%0d dload", c), bus.dload, (c == 5) ? 32'hDEADBEEF : 32'd0);
      @(posedge CLK); #1;
      if (c == 5) bus.dREN = 1'b0;
    end
    idle_inputs();

    // ---------------- randomized traffic against a transaction-level model
    do_reset(1);
    use_fixed = 1'b0;
    ref_mem = ram_mem;
    i_act = 1'b0; d_act = 1'b0; have = 1'b0; free_c = 0; g_c = 0; done_c = 0;
    prio_m = SRC_D; w_src = SRC_D; w_wr = 1'b0; w_addr = '0; w_store = '0; w_data = '0;
    for (int k = 0; k < 800; k++) begin
      if (!i_act) begin
        bus.iREN = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          i_act = 1'b1;
          idx = 4'($urandom_range(0, 15));
          bus.iREN = 1'b1;
          bus.iaddr = {26'd0, idx, 2'b00};
        end
      end
      if (!d_act) begin
        bus.dREN = 1'b0; bus.dWEN = 1'b0;
        if ($urandom_range(0, 2) == 0) begin
          d_act = 1'b1;
          op = int'($urandom_range(0, 2));
          idx = 4'($urandom_range(0, 15));
          bus.dREN = (op != 1);
          bus.dWEN = (op != 0);
          bus.daddr = {26'd0, idx, 2'b00};
          bus.dstore = $urandom;
        end
      end
      @(negedge CLK);
      in_acc   = have && (k > g_c) && (k <= g_c + LAT);
      done_now = have && (k == done_c);
      chk($sformatf("rnd k%0d iwait", k), 32'(bus.iwait), (done_now && w_src == SRC_I) ? 32'd0 : 32'd1);
      chk($sformatf("rnd k%0d dwait", k), 32'(bus.dwait), (done_now && w_src == SRC_D) ? 32'd0 : 32'd1);
      chk($sformatf("rnd k%0d iload", k), bus.iload, (done_now && w_src == SRC_I) ? w_data : 32'd0);
      chk($sformatf("rnd k%0d dload", k), bus.dload, (done_now && w_src == SRC_D) ? w_data : 32'd0);
      chk($sformatf("rnd k%0d ramREN", k), 32'(bus.ramREN), 32'(in_acc && !w_wr));
      chk($sformatf("rnd k%0d ramWEN", k), 32'(bus.ramWEN), 32'(in_acc && w_wr));
      if (in_acc) chk($sformatf("rnd k%0d ramaddr", k), bus.ramaddr, w_addr);
      if (in_acc && w_wr) chk($sformatf("rnd k%0d ramstore", k), bus.ramstore, w_store);
      if (done_now) begin
        have = 1'b0;
        if (w_src == SRC_I) i_act = 1'b0;
        else                d_act = 1'b0;
`ifdef MEMCTL_RR_EN
        prio_m = (prio_m == SRC_D) ? SRC_I : SRC_D;
`endif
      end
      if (!have && k >= free_c && (i_act || d_act)) begin
        if (i_act && d_act) begin
`ifdef MEMCTL_RR_EN
          w_src = prio_m;
`else
          w_src = SRC_D;
`endif
        end else begin
          w_src = d_act ? SRC_D : SRC_I;
        end
        w_wr    = (w_src == SRC_D) && bus.dWEN;
        w_addr  = (w_src == SRC_D) ? bus.daddr : bus.iaddr;
        w_store = bus.dstore;
        if (w_wr) begin
          ref_mem[w_addr[5:2]] = w_store;
          w_data = '0;
        end else begin
          w_data = ref_mem[w_addr[5:2]];
        end
        g_c = k; done_c = k + LAT + 1; free_c = k + LAT + 2; have = 1'b1;
      end
      @(posedge CLK); #1;
    end
    idle_inputs();

    // ---------------- RAM_LAT=1 instance: single dcache read
    RST1 = 1'b0;
    bus1.dREN = 1'b1; bus1.daddr = 32'h100;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk($sformatf("lat1 c%0d dwait", c), 32'(bus1.dwait), (c == 2) ? 32'd0 : 32'd1);
      chk($sformatf("lat1 c%0d dload", c), bus1.dload, (c == 2) ? 32'hDEADBEEF : 32'd0);
      chk($sformatf("lat1 c%0d ramREN", c), 32'(bus1.ramREN), (c == 1) ? 32'd1 : 32'd0);
      @(posedge CLK); #1;
      if (c == 2) bus1.dREN = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
